// File: rtl/fifo_read_serializer.sv
// fifo_read_serializer
//
// Read-side consumer for a first-word-fall-through FIFO. Pops one IN_WIDTH
// word into a holding register and presents it as IN_WIDTH/OUT_WIDTH slices
// on a valid/ready stream, with m_last marking the final slice of each word.
//
// Parameters
//   IN_WIDTH   FIFO word width (integer multiple of OUT_WIDTH)
//   OUT_WIDTH  output slice width
//   LSB_FIRST  1: slice 0 is bits [OUT_WIDTH-1:0]; 0: slice 0 is the MS slice
//
// Ports
//   rclk        FIFO read-side clock
//   rst         synchronous reset, active-high
//   fifo_dout   FIFO head word (valid while fifo_empty=0)
//   fifo_empty  FIFO empty flag
//   fifo_rget   single-cycle pop strobe to the FIFO
//   flush       drop the word in progress / suppress a pop
//   m_data      current slice
//   m_valid     slice valid
//   m_last      final slice of the word
//   m_ready     downstream accept
//   busy        a word is held (state SEND)
//   word_count  saturating count of pops (only with FIFO_READ_SERIALIZER_WORDCNT_EN)
//
// Optional feature macro: FIFO_READ_SERIALIZER_WORDCNT_EN
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | no word held; pops the FIFO head as soon as it is non-empty
// SEND  | word held; slices presented in order until the last is accepted
module fifo_read_serializer #(
   parameter int IN_WIDTH  = 32,
   parameter int OUT_WIDTH = 8,
   parameter bit LSB_FIRST = 1'b1
) (
   input  logic                 rclk,
   input  logic                 rst,
   input  logic [IN_WIDTH-1:0]  fifo_dout,
   input  logic                 fifo_empty,
   output logic                 fifo_rget,
   input  logic                 flush,
   output logic [OUT_WIDTH-1:0] m_data,
   output logic                 m_valid,
   output logic                 m_last,
   input  logic                 m_ready,
   output logic                 busy
`ifdef FIFO_READ_SERIALIZER_WORDCNT_EN
   ,
   output logic [31:0]          word_count
`endif
);

   localparam int N     = IN_WIDTH / OUT_WIDTH;
   localparam int IDX_W = (N > 1) ? $clog2(N) : 1;
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N - 1);

   typedef enum logic {
      IDLE = 1'b0,
      SEND = 1'b1
   } state_t;

   state_t                         state;
   state_t                         state_nxt;
   logic [IDX_W-1:0]               idx;
   logic [IDX_W-1:0]               idx_nxt;
   logic [IDX_W-1:0]               sel;
   logic [N-1:0][OUT_WIDTH-1:0]    hold;
   logic                           load;
   logic                           at_last;

   assign at_last = (idx == IDX_LAST);

   // Slice selection only depends on registered state, so m_data stays
   // stable for as long as the beat is stalled.
   always_comb begin
      sel = LSB_FIRST ? idx : (IDX_LAST - idx);
      m_data = hold[sel];
   end

   always_ff @(posedge rclk) begin
      if (rst) begin
         state <= IDLE;
         idx   <= '0;
         hold  <= '0;
      end else begin
         state <= state_nxt;
         idx   <= idx_nxt;
         if (load) begin
            hold <= fifo_dout;
         end
      end
   end

   // No lookahead pop in SEND: the FIFO needs two cycles to present a fresh
   // head, and SEND always lasts at least one cycle, so IDLE never samples a
   // stale head. The pop is also held off during reset so a word is never
   // removed from the FIFO without being captured.
   always_comb begin
      state_nxt = state;
      idx_nxt   = idx;
      load      = 1'b0;
      fifo_rget = 1'b0;
      m_valid   = 1'b0;
      m_last    = 1'b0;
      busy      = 1'b0;
      case (state)
         IDLE: begin
            if (!rst && !fifo_empty && !flush) begin
               fifo_rget = 1'b1;
               load      = 1'b1;
               idx_nxt   = '0;
               state_nxt = SEND;
            end
         end
         SEND: begin
            m_valid = 1'b1;
            m_last  = at_last;
            busy    = 1'b1;
            if (flush) begin
               idx_nxt   = '0;
               state_nxt = IDLE;
            end else if (m_ready) begin
               if (at_last) begin
                  idx_nxt   = '0;
                  state_nxt = IDLE;
               end else begin
                  idx_nxt = idx + IDX_W'(1);
               end
            end
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

`ifdef FIFO_READ_SERIALIZER_WORDCNT_EN
   // Flush deliberately leaves the count alone: it tracks words taken from
   // the FIFO, not words delivered downstream.
   always_ff @(posedge rclk) begin
      if (rst) begin
         word_count <= '0;
      end else if (fifo_rget && (word_count != 32'hFFFF_FFFF)) begin
         word_count <= word_count + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_fifo_read_serializer.sv
module tb_fifo_read_serializer;

   logic        rclk;
   logic        rst;
   logic [31:0] fifo_dout;
   logic        fifo_empty;
   logic        fifo_rget;
   logic        flush;
   logic [7:0]  m_data;
   logic        m_valid;
   logic        m_last;
   logic        m_ready;
   logic        busy;

   // second instance, MS slice first, fed from a one-word FIFO stand-in
   logic [31:0] dout2;
   logic        empty2;
   logic        rget2;
   logic        flush2;
   logic [7:0]  m_data2;
   logic        m_valid2;
   logic        m_last2;
   logic        m_ready2;
   logic        busy2;

`ifdef FIFO_READ_SERIALIZER_WORDCNT_EN
   logic [31:0] word_count;
   logic [31:0] word_count2;
`endif

   fifo_read_serializer #(.IN_WIDTH(32), .OUT_WIDTH(8), .LSB_FIRST(1'b1)) dut (
      .rclk(rclk), .rst(rst), .fifo_dout(fifo_dout), .fifo_empty(fifo_empty),
      .fifo_rget(fifo_rget), .flush(flush), .m_data(m_data), .m_valid(m_valid),
      .m_last(m_last), .m_ready(m_ready), .busy(busy)
`ifdef FIFO_READ_SERIALIZER_WORDCNT_EN
      , .word_count(word_count)
`endif
   );

   fifo_read_serializer #(.IN_WIDTH(32), .OUT_WIDTH(8), .LSB_FIRST(1'b0)) dut_msb (
      .rclk(rclk), .rst(rst), .fifo_dout(dout2), .fifo_empty(empty2),
      .fifo_rget(rget2), .flush(flush2), .m_data(m_data2), .m_valid(m_valid2),
      .m_last(m_last2), .m_ready(m_ready2), .busy(busy2)
`ifdef FIFO_READ_SERIALIZER_WORDCNT_EN
      , .word_count(word_count2)
`endif
   );

   initial rclk = 1'b0;
   always #5 rclk = ~rclk;

   // FWFT FIFO model: head/empty move one edge after the edge that took the pop
   logic [31:0] mem [0:15];
   logic [3:0]  wr_ptr;
   logic [3:0]  rd_ptr;
   logic        pop_d;

   assign fifo_dout  = mem[rd_ptr];
   assign fifo_empty = (rd_ptr == wr_ptr);

   initial begin
      rd_ptr = '0;
      pop_d  = 1'b0;
   end

   always @(posedge rclk) begin
      pop_d <= fifo_rget;
      if (pop_d) rd_ptr <= rd_ptr + 4'd1;
   end

   // accepted beats {last,data} and pop strobe count
   logic [8:0] beats [$];
   int         rget_cnt;
   initial rget_cnt = 0;

   always @(posedge rclk) begin
      if (!rst && m_valid && m_ready) beats.push_back({m_last, m_data});
      if (fifo_rget) rget_cnt++;
   end

   int n_chk;
   int n_bad;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic push(input logic [31:0] w);
      mem[wr_ptr] = w;
      wr_ptr = wr_ptr + 4'd1;
   endtask

   task automatic check_beats(input string tag, input logic [8:0] exp [$]);
      check({tag, "_n"}, 64'(beats.size()), 64'(exp.size()));
      foreach (exp[i]) begin
         if (i < beats.size()) check(tag, 64'(beats[i]), 64'(exp[i]));
         else check(tag, 64'h1FF_DEAD, 64'(exp[i]));
      end
   endtask

   logic [8:0] exp_q [$];
   int         rget_base;
   logic       pv, pr, pl;
   logic [7:0] pd;

   initial begin
      n_chk = 0; n_bad = 0;
      wr_ptr = '0;
      rst = 1'b1; flush = 1'b0; m_ready = 1'b0;
      dout2 = 32'hA1B2C3D4; empty2 = 1'b1; flush2 = 1'b0; m_ready2 = 1'b0;
      repeat (3) @(negedge rclk);

      // reset values
      check("rst_valid", m_valid, 1'b0);
      check("rst_last", m_last, 1'b0);
      check("rst_data", m_data, 8'h00);
      check("rst_rget", fifo_rget, 1'b0);
      check("rst_busy", busy, 1'b0);
      rst = 1'b0;
      repeat (2) @(negedge rclk);

      // LSB first, m_ready held high
      m_ready = 1'b1;
      rget_base = rget_cnt;
      push(32'hA1B2C3D4);
      #1;
      check("t1_rget", fifo_rget, 1'b1);
      @(negedge rclk);
      check("t1_s0", {m_valid, m_last, m_data}, {2'b10, 8'hD4});
      check("t1_busy", busy, 1'b1);
      check("t1_rget_off", fifo_rget, 1'b0);
      @(negedge rclk);
      check("t1_s1", {m_valid, m_last, m_data}, {2'b10, 8'hC3});
      @(negedge rclk);
      check("t1_s2", {m_valid, m_last, m_data}, {2'b10, 8'hB2});
      @(negedge rclk);
      check("t1_s3", {m_valid, m_last, m_data}, {2'b11, 8'hA1});
      @(negedge rclk);
      check("t1_done", m_valid, 1'b0);
      check("t1_npop", 64'(rget_cnt - rget_base), 64'd1);
      repeat (2) @(negedge rclk);

      // MS slice first
      m_ready2 = 1'b1;
      empty2 = 1'b0;
      #1;
      check("t2_rget", rget2, 1'b1);
      @(negedge rclk);
      empty2 = 1'b1;
      check("t2_s0", {m_valid2, m_last2, m_data2}, {2'b10, 8'hA1});
      @(negedge rclk);
      check("t2_s1", {m_valid2, m_last2, m_data2}, {2'b10, 8'hB2});
      @(negedge rclk);
      check("t2_s2", {m_valid2, m_last2, m_data2}, {2'b10, 8'hC3});
      @(negedge rclk);
      check("t2_s3", {m_valid2, m_last2, m_data2}, {2'b11, 8'hD4});
      @(negedge rclk);
      check("t2_done", {m_valid2, rget2}, 2'b00);

      // two words, m_ready alternating 1,0,1,0
      beats.delete();
      rget_base = rget_cnt;
      push(32'h11223344);
      push(32'h55667788);
      pv = 1'b0; pr = 1'b0; pl = 1'b0; pd = 8'h00;
      for (int i = 0; i < 30; i++) begin
         if (pv && !pr) check("t3_stable", {m_valid, m_last, m_data}, {1'b1, pl, pd});
         pv = m_valid; pl = m_last; pd = m_data;
         m_ready = (i % 2 == 0);
         pr = m_ready;
         @(negedge rclk);
      end
      m_ready = 1'b1;
      exp_q = '{9'h044, 9'h033, 9'h022, 9'h111, 9'h088, 9'h077, 9'h066, 9'h155};
      check_beats("t3_beat", exp_q);
      check("t3_npop", 64'(rget_cnt - rget_base), 64'd2);

      // flush after two slices
      push(32'hDEADBEEF);
      @(negedge rclk);
      check("t4_s0", m_data, 8'hEF);
      @(negedge rclk);
      check("t4_s1", m_data, 8'hBE);
      @(negedge rclk);
      check("t4_s2", {m_valid, m_data}, {1'b1, 8'hAD});
      flush = 1'b1;
      @(negedge rclk);
      flush = 1'b0;
      check("t4_drop", {m_valid, busy}, 2'b00);
      beats.delete();
      push(32'h01020304);
      repeat (7) @(negedge rclk);
      exp_q = '{9'h004, 9'h003, 9'h002, 9'h101};
      check_beats("t4_beat", exp_q);

      // reset mid-word at idx=2
      push(32'h0A0B0C0D);
      push(32'h10203040);
      @(negedge rclk);
      check("t5_s0", m_data, 8'h0D);
      @(negedge rclk);
      @(negedge rclk);
      check("t5_s2", {m_valid, m_data}, {1'b1, 8'h0B});
      rst = 1'b1;
      @(negedge rclk);
      check("t5_rst", {m_valid, fifo_rget, busy}, 3'b000);
      rst = 1'b0;
      beats.delete();
      repeat (7) @(negedge rclk);
      exp_q = '{9'h040, 9'h030, 9'h020, 9'h110};
      check_beats("t5_beat", exp_q);

`ifdef FIFO_READ_SERIALIZER_WORDCNT_EN
      rst = 1'b1;
      @(negedge rclk);
      rst = 1'b0;
      check("wc_rst", word_count, 32'd0);
      for (int i = 0; i < 5; i++) push(32'h100 + 32'(i));
      repeat (30) @(negedge rclk);
      check("wc_five", word_count, 32'd5);
      push(32'hCAFEF00D);
      @(negedge rclk);
      flush = 1'b1;
      @(negedge rclk);
      flush = 1'b0;
      check("wc_flush", word_count, 32'd6);
      repeat (2) @(negedge rclk);
      check("wc_flush_hold", word_count, 32'd6);
      rst = 1'b1;
      @(negedge rclk);
      rst = 1'b0;
      check("wc_clear", word_count, 32'd0);
`endif

      $display("test done: total=%0d bad=%0d", n_chk, n_bad);
      $finish;
   end

endmodule
